// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction sequencer FSM (fetch/decode/execute/update); define PC_SEQ_TIMEOUT_EN to enable the fetch timeout and FAULT state
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        stall,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        d_nz,
  output logic [15:0] ir,
  output logic [1:0]  pc_ps,
  output logic [1:0]  pc_bc,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    UPDATE  = 3'd4,
    HALT    = 3'd5,
    FAULT   = 3'd6
  } state_t;
  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic [3:0]  w_op;
  assign w_op  = r_ir[15:12];
  assign ir    = r_ir;
  assign state = r_state;
`ifdef PC_SEQ_TIMEOUT_EN
  logic [3:0] r_to;
  logic       w_timeout;
  assign w_timeout = (r_to == 4'd15);
  // Count unacknowledged FETCH cycles; held at zero outside FETCH so every entry starts fresh
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_to <= '0;
    else if (r_state != FETCH) r_to <= '0;
    else if (!imem_ack) r_to <= r_to + 4'd1;
  end
`else
  logic w_timeout;
  assign w_timeout = 1'b0;
`endif
  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Instruction register captures the fetched word only on an acknowledged FETCH cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ir <= '0;
    else if (r_state == FETCH && imem_ack) r_ir <= imem_data;
  end
  // Next-state and decoded outputs; ack wins over timeout on the final FETCH cycle
  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    pc_ps    = 2'd0;
    pc_bc    = 2'd3;
    halted   = (r_state == HALT);
`ifdef PC_SEQ_TIMEOUT_EN
    fault    = (r_state == FAULT);
`else
    fault    = 1'b0;
`endif
    case (r_state)
      IDLE:    w_next = run ? FETCH : IDLE;
      FETCH: begin
        imem_req = 1'b1;
        w_next   = imem_ack ? DECODE : (w_timeout ? FAULT : FETCH);
      end
      DECODE:  w_next = stall ? DECODE : EXECUTE;
      EXECUTE: begin
        rf_we  = !stall && (w_op <= 4'hA);
        w_next = stall ? EXECUTE : UPDATE;
      end
      UPDATE: begin
        w_next = (w_op == 4'hF) ? HALT : FETCH;
        case (w_op)
          4'hB: pc_ps = 2'd3;
          4'hC: begin
            pc_ps = d_nz ? 2'd1 : 2'd2;
            pc_bc = d_nz ? 2'd3 : 2'd0;
          end
          4'hD: begin
            pc_ps = d_nz ? 2'd2 : 2'd1;
            pc_bc = d_nz ? 2'd1 : 2'd3;
          end
          4'hE:    pc_ps = 2'd2;
          4'hF:    pc_ps = 2'd0;
          default: pc_ps = 2'd1;
        endcase
      end
      HALT:    w_next = HALT;
      FAULT:   w_next = FAULT;
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven check of pc_sequencer plus hand-written reset and timeout sequences
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0;
  logic        d_nz = 1'b0;
  logic [15:0] ir;
  logic [1:0]  pc_ps;
  logic [1:0]  pc_bc;
  logic        rf_we;
  logic [2:0]  state;
  logic        halted;
  logic        fault;
  int total = 0;
  int bad = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data), .d_nz(d_nz),
    .ir(ir), .pc_ps(pc_ps), .pc_bc(pc_bc), .rf_we(rf_we),
    .state(state), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run, stall, ack;
    logic [15:0] data;
    logic        dnz;
    logic [2:0]  st;
    logic        req, we;
    logic [1:0]  ps, bc;
    logic [15:0] ir;
    logic        hlt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, s, a, input logic [15:0] dat, input logic dn,
                     input logic [2:0] st, input logic rq, w, input logic [1:0] ps, bc,
                     input logic [15:0] irv, input logic h);
    vec_t v;
    v.run = r; v.stall = s; v.ack = a; v.data = dat; v.dnz = dn;
    v.st = st; v.req = rq; v.we = w; v.ps = ps; v.bc = bc; v.ir = irv; v.hlt = h;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx, input logic [2:0] st, input logic rq, w,
                         input logic [1:0] ps, bc, input logic [15:0] irv, input logic h, f);
    chk({nm, ".state"}, idx, {13'd0, state}, {13'd0, st});
    chk({nm, ".imem_req"}, idx, {15'd0, imem_req}, {15'd0, rq});
    chk({nm, ".rf_we"}, idx, {15'd0, rf_we}, {15'd0, w});
    chk({nm, ".pc_ps"}, idx, {14'd0, pc_ps}, {14'd0, ps});
    chk({nm, ".pc_bc"}, idx, {14'd0, pc_bc}, {14'd0, bc});
    chk({nm, ".ir"}, idx, ir, irv);
    chk({nm, ".halted"}, idx, {15'd0, halted}, {15'd0, h});
    chk({nm, ".fault"}, idx, {15'd0, fault}, {15'd0, f});
  endtask

  task automatic drive(input logic r, s, a, input logic [15:0] dat, input logic dn);
    run = r; stall = s; imem_ack = a; imem_data = dat; d_nz = dn;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 16'h0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // ADD-class, BZ taken/untaken, JR with decode stall, op A with execute stall, BNZ taken, JMP, HALT
    add(0,0,0,16'h0000,0, 0,0,0,0,3,16'h0000,0);
    add(1,0,0,16'h0000,0, 0,0,0,0,3,16'h0000,0);
    add(0,0,1,16'h1234,0, 1,1,0,0,3,16'h0000,0);
    add(0,0,0,16'h0000,0, 2,0,0,0,3,16'h1234,0);
    add(0,0,0,16'h0000,0, 3,0,1,0,3,16'h1234,0);
    add(0,0,0,16'h0000,0, 4,0,0,1,3,16'h1234,0);
    add(0,0,1,16'hC0F0,0, 1,1,0,0,3,16'h1234,0);
    add(0,0,0,16'h0000,0, 2,0,0,0,3,16'hC0F0,0);
    add(0,0,0,16'h0000,0, 3,0,0,0,3,16'hC0F0,0);
    add(0,0,0,16'h0000,0, 4,0,0,2,0,16'hC0F0,0);
    add(0,0,0,16'h0000,0, 1,1,0,0,3,16'hC0F0,0);
    add(0,0,1,16'hC0F0,0, 1,1,0,0,3,16'hC0F0,0);
    add(0,0,1,16'hFFFF,1, 2,0,0,0,3,16'hC0F0,0);
    add(0,0,0,16'h0000,1, 3,0,0,0,3,16'hC0F0,0);
    add(0,0,0,16'h0000,1, 4,0,0,1,3,16'hC0F0,0);
    add(0,0,1,16'hB020,0, 1,1,0,0,3,16'hC0F0,0);
    add(0,1,0,16'h0000,0, 2,0,0,0,3,16'hB020,0);
    add(0,0,0,16'h0000,0, 2,0,0,0,3,16'hB020,0);
    add(0,0,0,16'h0000,0, 3,0,0,0,3,16'hB020,0);
    add(0,0,0,16'h0000,0, 4,0,0,3,3,16'hB020,0);
    add(0,1,1,16'hA5A5,0, 1,1,0,0,3,16'hB020,0);
    add(0,0,0,16'h0000,0, 2,0,0,0,3,16'hA5A5,0);
    add(0,1,0,16'h0000,0, 3,0,0,0,3,16'hA5A5,0);
    add(0,1,0,16'h0000,0, 3,0,0,0,3,16'hA5A5,0);
    add(0,1,0,16'h0000,0, 3,0,0,0,3,16'hA5A5,0);
    add(0,0,0,16'h0000,0, 3,0,1,0,3,16'hA5A5,0);
    add(0,1,0,16'h0000,0, 4,0,0,1,3,16'hA5A5,0);
    add(0,0,1,16'hD000,0, 1,1,0,0,3,16'hA5A5,0);
    add(0,0,0,16'h0000,0, 2,0,0,0,3,16'hD000,0);
    add(0,0,0,16'h0000,0, 3,0,0,0,3,16'hD000,0);
    add(0,0,0,16'h0000,1, 4,0,0,2,1,16'hD000,0);
    add(0,0,1,16'hE123,0, 1,1,0,0,3,16'hD000,0);
    add(0,0,0,16'h0000,0, 2,0,0,0,3,16'hE123,0);
    add(0,0,0,16'h0000,0, 3,0,0,0,3,16'hE123,0);
    add(0,0,0,16'h0000,0, 4,0,0,2,3,16'hE123,0);
    add(0,0,1,16'hF000,0, 1,1,0,0,3,16'hE123,0);
    add(0,0,0,16'h0000,0, 2,0,0,0,3,16'hF000,0);
    add(0,0,0,16'h0000,0, 3,0,0,0,3,16'hF000,0);
    add(0,0,0,16'h0000,0, 4,0,0,0,3,16'hF000,0);
    add(1,0,1,16'h1111,0, 5,0,0,0,3,16'hF000,1);
    add(1,0,0,16'h0000,1, 5,0,0,0,3,16'hF000,1);
    add(1,1,1,16'h2222,0, 5,0,0,0,3,16'hF000,1);

    @(negedge clk);
    @(negedge clk);
    #1 chk_all("reset", 0, 3'd0, 0, 0, 2'd0, 2'd3, 16'h0000, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].run, tbl[i].stall, tbl[i].ack, tbl[i].data, tbl[i].dnz);
      #1 chk_all("vec", i, tbl[i].st, tbl[i].req, tbl[i].we, tbl[i].ps, tbl[i].bc, tbl[i].ir, tbl[i].hlt, 0);
      @(negedge clk);
    end

    // Asynchronous reset out of HALT, applied mid-cycle
    reset = 1'b1;
    #1 chk_all("halt_reset", 0, 3'd0, 0, 0, 2'd0, 2'd3, 16'h0000, 0, 0);
    drive(0, 0, 0, 16'h0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-FETCH drops imem_req at once and discards the concurrent ack
    drive(1, 0, 0, 16'h0, 0);
    @(negedge clk);
    drive(0, 0, 1, 16'hBEEF, 0);
    #1 chk("mid_fetch.req_before", 0, {15'd0, imem_req}, 16'd1);
    reset = 1'b1;
    #1 chk("mid_fetch.req_after", 0, {15'd0, imem_req}, 16'd0);
    @(negedge clk);
    #1 chk_all("mid_fetch", 0, 3'd0, 0, 0, 2'd0, 2'd3, 16'h0000, 0, 0);
    do_reset();

`ifdef PC_SEQ_TIMEOUT_EN
    // Sixteen unacknowledged FETCH cycles enter sticky FAULT
    drive(1, 0, 0, 16'h0, 0);
    @(negedge clk);
    drive(0, 0, 0, 16'h0, 0);
    for (int i = 1; i <= 16; i++) begin
      #1 chk("to.fetch_state", i, {13'd0, state}, 16'd1);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 16'h4444, 1);
      #1 chk_all("to.fault", i, 3'd6, 0, 0, 2'd0, 2'd3, 16'h0000, 0, 1);
      @(negedge clk);
    end
    do_reset();
    #1 chk_all("to.reset", 0, 3'd0, 0, 0, 2'd0, 2'd3, 16'h0000, 0, 0);
    // Ack on the sixteenth cycle beats the timeout
    drive(1, 0, 0, 16'h0, 0);
    @(negedge clk);
    drive(0, 0, 0, 16'h0, 0);
    for (int i = 1; i <= 15; i++) @(negedge clk);
    drive(0, 0, 1, 16'h3333, 0);
    #1 chk("to.ack16_state", 0, {13'd0, state}, 16'd1);
    @(negedge clk);
    drive(0, 0, 0, 16'h0, 0);
    #1 chk_all("to.ack16", 0, 3'd2, 0, 0, 2'd0, 2'd3, 16'h3333, 0, 0);
`else
    // Without the timeout, FETCH waits indefinitely and fault stays low
    drive(1, 0, 0, 16'h0, 0);
    @(negedge clk);
    drive(0, 0, 0, 16'h0, 0);
    for (int i = 1; i <= 20; i++) @(negedge clk);
    #1 chk_all("no_to.wait", 0, 3'd1, 1, 0, 2'd0, 2'd3, 16'h0000, 0, 0);
    drive(0, 0, 1, 16'h3333, 0);
    @(negedge clk);
    drive(0, 0, 0, 16'h0, 0);
    #1 chk_all("no_to.ack", 0, 3'd2, 0, 0, 2'd0, 2'd3, 16'h3333, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
